ema_state_update_pipe: RTL

//   Fully pipelined, multi-lane EMA state update: s_new = lam*s_prev + (1-lam)*u per lane.

---
 rtl/ema_pkg.sv | 30 +++
 rtl/ema_lane_mac.sv | 53 +++++
 rtl/ema_state_update_pipe.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/ema_pkg.sv
// Shared types and arithmetic helpers for the EMA state update pipe.
// Holds the control FSM state type, the Q0.16 "one" constant and the
// round-half-up / saturate helper used by every lane.
package ema_pkg;

  typedef enum logic [1:0] {RUN, DRAIN, CLEAR} ema_st_t;

  // Fraction width of lam; the top-level LAM_W defaults to this.
  localparam int Q_BITS = 16;

  // 1.0 in Q0.Q_BITS, one bit wider than lam so that lam=0 gives om=1.0.
  localparam logic [Q_BITS:0] ONE_Q = {1'b1, {Q_BITS{1'b0}}};

  // Round half-up by adding half an LSB of the result, arithmetic shift
  // right by lam_w, then clamp to the signed w-bit range.
  function automatic logic signed [63:0] rnd_sat(input logic signed [63:0] p,
                                                 input int lam_w,
                                                 input int w);
    logic signed [63:0] r;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    r  = (p + (64'sd1 <<< (lam_w - 1))) >>> lam_w;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (r > hi) return hi;
    if (r < lo) return lo;
    return r;
  endfunction

endpackage

// File: rtl/ema_lane_mac.sv
// One lane of the EMA update: s_new = lam*s_prev + (1-lam)*u.
// Latency 2 (product register, then rounded/saturated result register).
// Backpressure: en holds the product stage, out_ld gates the result register.
// Ports: clk/rst_n; en, out_ld stage enables; lam (Q0.LAM_W), s_prev, u
//   (signed Q.FRAC); s_nxt is the combinational result feeding the RAM
//   write, s_q the registered result.
module ema_lane_mac
  import ema_pkg::*;
#(
  parameter int W     = 16,
  parameter int LAM_W = Q_BITS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             out_ld,
  input  logic [LAM_W-1:0] lam,
  input  logic [W-1:0]     s_prev,
  input  logic [W-1:0]     u,
  output logic [W-1:0]     s_nxt,
  output logic [W-1:0]     s_q
);

  localparam int PW = W + LAM_W + 2;

  logic        [LAM_W:0] om;
  logic signed [PW-2:0]  prod_s;
  logic signed [PW-1:0]  prod_u;
  logic signed [PW-1:0]  psum;

  assign om = ONE_Q - {1'b0, lam};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_s <= '0;
      prod_u <= '0;
      s_q    <= '0;
    end else begin
      if (en) begin
        // lam is unsigned, so it gets a zero MSB before the signed multiply.
        prod_s <= (PW-1)'($signed({1'b0, lam})) * (PW-1)'($signed(s_prev));
        prod_u <= PW'($signed({1'b0, om}))      * PW'($signed(u));
      end
      if (out_ld) begin
        s_q <= s_nxt;
      end
    end
  end

  assign psum  = PW'(prod_s) + prod_u;
  assign s_nxt = W'(rnd_sat(64'(psum), LAM_W, W));

endmodule

// File: rtl/ema_state_update_pipe.sv
// Multi-lane EMA state update with an internal state RAM written back in place.
// Latency RD_LAT+2 cycles from accept to out_valid when not stalled.
// Backpressure: whole pipe holds while out_valid && !out_ready; in_ready drops
//   then, on a same-address hazard, and while a clear is pending or running.
// Ports: clk, rst_n; in_valid/in_ready with in_lam, in_u, in_addr, in_init;
//   clr_start pulse and busy status; out_valid/out_ready with out_s, out_addr.
module ema_state_update_pipe
  import ema_pkg::*;
#(
  parameter int LANES    = 4,
  parameter int W        = 16,
  parameter int FRAC     = 8,
  parameter int LAM_W    = Q_BITS,
  parameter int S_ADDR_W = 6,
  parameter int RD_LAT   = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*LAM_W-1:0] in_lam,
  input  logic [LANES*W-1:0]     in_u,
  input  logic [S_ADDR_W-1:0]    in_addr,
  input  logic                   in_init,
  input  logic                   clr_start,
  output logic                   busy,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*W-1:0]     out_s,
  output logic [S_ADDR_W-1:0]    out_addr
);

  localparam int DEPTH = 2**S_ADDR_W;
  localparam int DW    = LANES * W;

  // FRAC only fixes how s and u are interpreted; the datapath is scale-free.
  if (FRAC >= W) begin : g_frac_out_of_range
  end

  ema_st_t             st;
  logic [S_ADDR_W-1:0] clr_cnt;
  logic                rst_done;
  logic                en;
  logic                hazard;
  logic                fire;
  logic                pipe_empty;
  logic                out_ld;

  logic [DW-1:0]       mem [DEPTH];

  logic [RD_LAT-1:0]      rd_vld;
  logic [RD_LAT-1:0]      rd_init;
  logic [S_ADDR_W-1:0]    rd_addr [RD_LAT];
  logic [LANES*LAM_W-1:0] rd_lam  [RD_LAT];
  logic [DW-1:0]          rd_u    [RD_LAT];
  logic [DW-1:0]          rd_dat  [RD_LAT];

  logic                mul_vld;
  logic [S_ADDR_W-1:0] mul_addr;

  logic [DW-1:0]       s_prev;
  logic [DW-1:0]       s_nxt;

  logic                we;
  logic [S_ADDR_W-1:0] waddr;
  logic [DW-1:0]       wdata;

  assign en     = !out_valid || out_ready;
  assign out_ld = en && mul_vld;

  // Any live entry at the same address blocks the token. The out register is
  // included so that the new read always lands strictly after the write.
  always_comb begin
    hazard = (out_valid && (out_addr == in_addr)) ||
             (mul_vld && (mul_addr == in_addr));
    for (int i = 0; i < RD_LAT; i++) begin
      if (rd_vld[i] && (rd_addr[i] == in_addr)) hazard = 1'b1;
    end
  end

  // A token offered together with clr_start is refused.
  assign in_ready   = rst_done && en && !hazard && (st == RUN) && !clr_start;
  assign fire       = in_valid && in_ready;
  assign pipe_empty = !(|rd_vld) && !mul_vld && !out_valid;

  // Single write port: the clear sweep owns it in CLEAR, otherwise the result
  // being loaded into the out register is written back to its own address.
  assign we    = (st == CLEAR) || out_ld;
  assign waddr = (st == CLEAR) ? clr_cnt : mul_addr;
  assign wdata = (st == CLEAR) ? '0 : s_nxt;

  // State RAM and read-side data pipe (not reset).
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (en) begin
      rd_dat[0]  <= (we && (waddr == in_addr)) ? wdata : mem[in_addr];
      rd_addr[0] <= in_addr;
      rd_lam[0]  <= in_lam;
      rd_u[0]    <= in_u;
      rd_init[0] <= in_init;
      for (int i = 1; i < RD_LAT; i++) begin
        rd_dat[i]  <= rd_dat[i-1];
        rd_addr[i] <= rd_addr[i-1];
        rd_lam[i]  <= rd_lam[i-1];
        rd_u[i]    <= rd_u[i-1];
        rd_init[i] <= rd_init[i-1];
      end
    end
  end

  // Pipe valids and addresses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_vld    <= '0;
      mul_vld   <= 1'b0;
      mul_addr  <= '0;
      out_valid <= 1'b0;
      out_addr  <= '0;
      rst_done  <= 1'b0;
    end else begin
      rst_done <= 1'b1;
      if (en) begin
        rd_vld[0] <= fire;
        for (int i = 1; i < RD_LAT; i++) rd_vld[i] <= rd_vld[i-1];
        mul_vld   <= rd_vld[RD_LAT-1];
        mul_addr  <= rd_addr[RD_LAT-1];
        out_valid <= mul_vld;
        if (mul_vld) out_addr <= mul_addr;
      end
    end
  end

  // Clear control: RUN -> DRAIN on clr_start, DRAIN -> CLEAR once nothing is
  // left in flight, CLEAR sweeps every address once and returns to RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st      <= RUN;
      busy    <= 1'b0;
      clr_cnt <= '0;
    end else begin
      case (st)
        RUN: begin
          if (clr_start) begin
            st   <= DRAIN;
            busy <= 1'b1;
          end
        end
        DRAIN: begin
          if (pipe_empty) begin
            st      <= CLEAR;
            clr_cnt <= '0;
          end
        end
        CLEAR: begin
          clr_cnt <= clr_cnt + 1'b1;
          if (clr_cnt == S_ADDR_W'(DEPTH - 1)) begin
            st   <= RUN;
            busy <= 1'b0;
          end
        end
        default: begin
          st   <= RUN;
          busy <= 1'b0;
        end
      endcase
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign s_prev[i*W +: W] = rd_init[RD_LAT-1] ? '0 : rd_dat[RD_LAT-1][i*W +: W];

    ema_lane_mac #(
      .W     (W),
      .LAM_W (LAM_W)
    ) u_mac (
      .clk    (clk),
      .rst_n  (rst_n),
      .en     (en),
      .out_ld (out_ld),
      .lam    (rd_lam[RD_LAT-1][i*LAM_W +: LAM_W]),
      .s_prev (s_prev[i*W +: W]),
      .u      (rd_u[RD_LAT-1][i*W +: W]),
      .s_nxt  (s_nxt[i*W +: W]),
      .s_q    (out_s[i*W +: W])
    );
  end

endmodule
